// File: rtl/nand_seq_if.sv
// Requester and gate-side signal bundle for the shared bit-serial NAND scheduler.
// master: ALU front end plus the nand_1b gate; slave: nand_seq_ctrl.
interface nand_seq_if #(
    parameter int WIDTH = 8
);
    // requester 0
    logic             req0;
    logic [1:0]       op0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    // requester 1
    logic             req1;
    logic [1:0]       op1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    // handshake / result
    logic             gnt0;
    logic             gnt1;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] result;
    // shared 1-bit gate
    logic             nand_x;
    logic             nand_y;
    logic             nand_o;

    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1, nand_o,
        input  gnt0, gnt1, busy, done, done_id, result, nand_x, nand_y
    );

    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1, nand_o,
        output gnt0, gnt1, busy, done, done_id, result, nand_x, nand_y
    );
endinterface

// File: rtl/nand_seq_ctrl.sv
// Bit-serial scheduler sharing one external 1-bit NAND gate between two
// requesters. Each bit of NAND/AND/OR/XOR is built from 1..4 NAND micro-steps;
// requesters are served round-robin, result returned with a one-cycle done.
module nand_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    nand_seq_if.slave  bus
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {OP_NAND = 2'b00, OP_AND = 2'b01,
                              OP_OR   = 2'b10, OP_XOR = 2'b11} op_t;

    // operation latched at grant time
    typedef struct packed {
        op_t              op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             id;
    } job_t;

    state_t           state_q, state_d;
    job_t             job_q, job_in;
    logic [BW-1:0]    bit_q;
    logic [1:0]       step_q;
    logic             t_q, p_q, q_q;
    logic [WIDTH-1:0] shadow_q, shadow_nxt;
    logic [WIDTH-1:0] result_q;
    logic             last_q;
    logic             done_id_q;

    logic             win0, win1, grant;
    logic             a_i, b_i;
    logic             last_step, last_bit;
    logic             nx, ny;
    logic             cap_t, cap_p, cap_q;

    assign a_i       = job_q.a[bit_q];
    assign b_i       = job_q.b[bit_q];
    // the opcode value equals the index of the final micro-step (S-1)
    assign last_step = (step_q == 2'(job_q.op));
    assign last_bit  = (bit_q == BW'(WIDTH - 1));
    assign grant     = win0 | win1;

    // round-robin arbitration, only in IDLE; last_q=1 favours req0 on a tie
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (state_q == IDLE && !rst) begin
            if (bus.req0 && bus.req1) begin
                win0 = last_q;
                win1 = !last_q;
            end else begin
                win0 = bus.req0;
                win1 = bus.req1;
            end
        end
    end

    // pick the winning requester's operands for latching
    always_comb begin
        job_in.op = op_t'(win1 ? bus.op1 : bus.op0);
        job_in.a  = win1 ? bus.a1 : bus.a0;
        job_in.b  = win1 ? bus.b1 : bus.b0;
        job_in.id = win1;
    end

    // micro-step table: gate inputs and where the gate output lands
    always_comb begin
        nx    = 1'b0;
        ny    = 1'b0;
        cap_t = 1'b0;
        cap_p = 1'b0;
        cap_q = 1'b0;
        if (state_q == RUN) begin
            case (job_q.op)
                OP_NAND: begin
                    nx = a_i;
                    ny = b_i;
                end
                OP_AND: begin
                    case (step_q)
                        2'd0:    begin nx = a_i; ny = b_i; cap_t = 1'b1; end
                        default: begin nx = t_q; ny = t_q; end
                    endcase
                end
                OP_OR: begin
                    case (step_q)
                        2'd0:    begin nx = a_i; ny = a_i; cap_p = 1'b1; end
                        2'd1:    begin nx = b_i; ny = b_i; cap_q = 1'b1; end
                        default: begin nx = p_q; ny = q_q; end
                    endcase
                end
                OP_XOR: begin
                    case (step_q)
                        2'd0:    begin nx = a_i; ny = b_i; cap_t = 1'b1; end
                        2'd1:    begin nx = a_i; ny = t_q; cap_p = 1'b1; end
                        2'd2:    begin nx = b_i; ny = t_q; cap_q = 1'b1; end
                        default: begin nx = p_q; ny = q_q; end
                    endcase
                end
            endcase
        end
    end

    // shadow with the current bit replaced by the gate output (used on last step)
    always_comb begin
        shadow_nxt        = shadow_q;
        shadow_nxt[bit_q] = bus.nand_o;
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = RUN;
            RUN:     if (last_step && last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // datapath: latch job on grant, step through bits, publish result on DONE entry
    always_ff @(posedge clk) begin
        if (rst) begin
            job_q     <= '0;
            bit_q     <= '0;
            step_q    <= '0;
            t_q       <= 1'b0;
            p_q       <= 1'b0;
            q_q       <= 1'b0;
            shadow_q  <= '0;
            result_q  <= '0;
            last_q    <= 1'b1;
            done_id_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        job_q  <= job_in;
                        last_q <= job_in.id;
                        bit_q  <= '0;
                        step_q <= '0;
                    end
                end
                RUN: begin
                    if (last_step) begin
                        shadow_q <= shadow_nxt;
                        step_q   <= '0;
                        if (last_bit) begin
                            result_q  <= shadow_nxt;
                            done_id_q <= job_q.id;
                        end else begin
                            bit_q <= bit_q + BW'(1);
                        end
                    end else begin
                        step_q <= step_q + 2'd1;
                        if (cap_t) t_q <= bus.nand_o;
                        if (cap_p) p_q <= bus.nand_o;
                        if (cap_q) q_q <= bus.nand_o;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt0    = win0;
    assign bus.gnt1    = win1;
    assign bus.busy    = (state_q == RUN) || (state_q == DONE);
    assign bus.done    = (state_q == DONE);
    assign bus.done_id = done_id_q;
    assign bus.result  = result_q;
    assign bus.nand_x  = nx;
    assign bus.nand_y  = ny;
endmodule

// File: doc/nand_seq_ctrl.md
Name: nand_seq_ctrl

Overview:
Bit-serial scheduler that shares one external 1-bit NAND gate (nand_1b instance) between two requesters. It sequences NAND micro-steps per bit to compute NAND, AND, OR or XOR over WIDTH-bit operands. It arbitrates requesters round-robin and returns a WIDTH-bit result with a one-cycle done pulse. It sits between the ALU front end and the gate-level nand_1b datapath.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
req0  input  1  requester 0 request; held high until gnt0
op0  input  2  requester 0 opcode: 00 NAND, 01 AND, 10 OR, 11 XOR
a0  input  WIDTH  requester 0 operand A
b0  input  WIDTH  requester 0 operand B
req1  input  1  requester 1 request
op1  input  2  requester 1 opcode
a1  input  WIDTH  requester 1 operand A
b1  input  WIDTH  requester 1 operand B
gnt0  output  1  one-cycle pulse: requester 0 accepted, operands latched
gnt1  output  1  one-cycle pulse: requester 1 accepted
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse: result valid
done_id  output  1  requester that owns result (0/1), valid with done, held after
result  output  WIDTH  computed value, held until next done
nand_x  output  1  gate input x
nand_y  output  1  gate input y
nand_o  input  1  gate output, combinational from nand_x/nand_y, sampled same cycle

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; gnt0, gnt1, busy, done, done_id, result, nand_x, nand_y = 0; bit=0; step=0; temps t/p/q=0; last_grant=1, so req0 wins the first tie. Reset has priority over all other activity. Reset in RUN aborts the operation: no done, result cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - If any req is high, grant per round-robin: a lone requester wins; if both are high, the one not equal to last_grant wins.
  - On grant: pulse gntN; latch opN/aN/bN and id; set last_grant=id; go RUN with bit=0, step=0.
  - Requests are never seen in RUN/DONE, and no grant is issued there.
- RUN: one NAND per cycle on bit i = bit. Steps per bit S: NAND=1, AND=2, OR=3, XOR=4. Capture nand_o into the listed destination at the clock edge:
  - NAND: s0 x=a[i] y=b[i] -> result[i]
  - AND: s0 a[i],b[i] -> t; s1 t,t -> result[i]
  - OR: s0 a[i],a[i] -> p; s1 b[i],b[i] -> q; s2 p,q -> result[i]
  - XOR: s0 a[i],b[i] -> t; s1 a[i],t -> p; s2 b[i],t -> q; s3 p,q -> result[i]
  - After the last step: step=0, bit+1. After the last step of bit WIDTH-1, go DONE.
  - nand_x/nand_y are combinational from state/bit/step/latched operands/temps; they are 0 outside RUN.
- The result register is updated bit-wise during RUN. The result port shows the previous value until done: use a shadow register, copied to result on entry to DONE.
- DONE: done=1 and done_id valid for exactly one cycle, busy=1, then IDLE.
- Timing, grant at cycle 0: RUN occupies cycles 1..WIDTH*S; done is high in cycle WIDTH*S+1. The earliest next grant is cycle WIDTH*S+2.
- busy=1 from cycle 1 through the DONE cycle.
- Counters: bit is ceil(log2(WIDTH)) bits, step is 2 bits; no wrap beyond WIDTH-1.

Test Plan:
1. Reset; req0=1, op0=00, a0=F0, b0=CC, WIDTH=8 -> gnt0 at cycle 0, done at cycle 9, result=3F, done_id=0, busy cycles 1-9.
2. Same operands with op0=01 -> result=C0, done at cycle 17; op0=10 -> FC at cycle 25; op0=11 -> 3C at cycle 33. Check the nand_x/nand_y sequence for bit 0 of XOR: (0,0),(0,1),(0,1),(1,1).
3. req0 and req1 both high after reset, held -> gnt0 first; after done, gnt1 next (done_id=1); then gnt0 again (strict alternation); never both gnt in one cycle.
4. req1 rises during RUN of requester 0 -> gnt1=0 until IDLE, then gnt1 pulses at cycle WIDTH*S+2.
5. rst=1 at cycle 5 of an XOR run -> next cycle busy=0, result=00, nand_x=nand_y=0, no done pulse; a subsequent request completes normally.
6. Edge operands: a=FF, b=FF, XOR -> 00; a=00, b=00, NAND -> FF; result holds its value across idle cycles.
